// File: rtl/mac_seq_pkg.sv
// Shared lane geometry and sequencer state encoding for the MAC sequencer.
package mac_seq_pkg;
  localparam int LANES  = 9;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int VEC_W  = LANES * OP_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/mac_sequencer_if.sv
// Control, operand, multiplier-array and result signals of the MAC sequencer.
interface mac_sequencer_if
  import mac_seq_pkg::*;
#(
  parameter int SUM_W = 20,
  parameter int ACC_W = 32,
  parameter int GRP_W = 10
);
  logic             start;
  logic [GRP_W-1:0] num_groups;
  logic [ACC_W-1:0] bias;
  logic             busy;
  logic             err_start;
  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_md;
  logic [VEC_W-1:0] in_mr;
  logic [VEC_W-1:0] mul_md;
  logic [VEC_W-1:0] mul_mr;
  logic             mul_valid;
  logic [SUM_W-1:0] tree_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport slave (
    input  start, num_groups, bias, in_valid, in_md, in_mr, tree_sum, out_ready,
    output busy, err_start, in_ready, mul_md, mul_mr, mul_valid, out_valid, out_data
  );

  modport master (
    output start, num_groups, bias, in_valid, in_md, in_mr, tree_sum, out_ready,
    input  busy, err_start, in_ready, mul_md, mul_mr, mul_valid, out_valid, out_data
  );
endinterface

// File: rtl/valid_delay_line.sv
// DEPTH-stage 1-bit shift register; q marks when the external tree output is valid.
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr_q <= '0;
    else       sr_q <= (sr_q << 1) | DEPTH'(d);
  end

  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/mac_sequencer.sv
// Issues 9-lane operand groups to the multiplier array, tracks the tree
// latency and accumulates tree sums plus bias into one handshaked result.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int PIPE_LAT = 3,
  parameter int SUM_W    = 20,
  parameter int ACC_W    = 32,
  parameter int GRP_W    = 10
) (
  input logic            clk,
  input logic            reset,
  mac_sequencer_if.slave bus
);
  state_e                  state_q;
  logic [GRP_W-1:0]        ngrp_q, issued_q, retired_q;
  logic [GRP_W-1:0]        issued_inc, retired_inc;
  logic signed [ACC_W-1:0] acc_q, acc_d, out_data_q;
  logic [VEC_W-1:0]        mul_md_q, mul_mr_q;
  logic                    mul_valid_q, err_q, tap, accept, in_ready;

  function automatic logic signed [ACC_W-1:0] sext_sum(input logic [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] ss;
    ss = s;
    return ACC_W'(ss);
  endfunction

  // Plain two's-complement add: the result wraps modulo 2^ACC_W.
  function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
    return a + b;
  endfunction

  assign issued_inc  = issued_q + 1'b1;
  assign retired_inc = retired_q + 1'b1;
  assign in_ready    = (state_q == RUN) && (issued_q < ngrp_q);
  assign accept      = bus.in_valid && in_ready;
  assign acc_d       = tap ? wrap_add(acc_q, sext_sum(bus.tree_sum)) : acc_q;

  valid_delay_line #(.DEPTH(PIPE_LAT)) u_vdl (
    .clk   (clk),
    .reset (reset),
    .d     (mul_valid_q),
    .q     (tap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ngrp_q      <= '0;
      issued_q    <= '0;
      retired_q   <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      mul_md_q    <= '0;
      mul_mr_q    <= '0;
      mul_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= bus.start && (state_q != IDLE);
      mul_valid_q <= accept;
      mul_md_q    <= accept ? bus.in_md : '0;
      mul_mr_q    <= accept ? bus.in_mr : '0;
      if (accept) issued_q <= issued_inc;
      if (tap) begin
        acc_q     <= acc_d;
        retired_q <= retired_inc;
      end
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ngrp_q    <= bus.num_groups;
            acc_q     <= bus.bias;
            issued_q  <= '0;
            retired_q <= '0;
            if (bus.num_groups == '0) begin
              state_q    <= DONE;
              out_data_q <= bus.bias;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (accept && (issued_inc == ngrp_q)) state_q <= DRAIN;
        end
        DRAIN: begin
          // Leave as the final sum lands so out_valid follows it by one cycle.
          if (tap && (retired_inc == ngrp_q)) begin
            state_q    <= DONE;
            out_data_q <= acc_d;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.err_start = err_q;
  assign bus.in_ready  = in_ready;
  assign bus.mul_md    = mul_md_q;
  assign bus.mul_mr    = mul_mr_q;
  assign bus.mul_valid = mul_valid_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a delayed sum-of-products tree model.
module tb_mac_sequencer;
  localparam int PIPE_LAT = 3;
  localparam int SUM_W    = 20;
  localparam int ACC_W    = 32;
  localparam int GRP_W    = 10;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mac_sequencer_if #(.SUM_W(SUM_W), .ACC_W(ACC_W), .GRP_W(GRP_W)) bus ();

  mac_sequencer #(.PIPE_LAT(PIPE_LAT), .SUM_W(SUM_W), .ACC_W(ACC_W), .GRP_W(GRP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External multiplier array + adder tree model.
  logic [SUM_W-1:0] pipe_sum [PIPE_LAT] = '{default: '0};
  logic             pipe_v   [PIPE_LAT] = '{default: 1'b0};

  function automatic int tree(input logic [71:0] a, input logic [71:0] b);
    int s;
    logic signed [7:0] x, y;
    s = 0;
    for (int i = 0; i < 9; i++) begin
      x = a[8*i +: 8];
      y = b[8*i +: 8];
      s = s + int'(x) * int'(y);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    pipe_v[0]   <= bus.mul_valid;
    pipe_sum[0] <= SUM_W'(tree(bus.mul_md, bus.mul_mr));
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe_v[i]   <= pipe_v[i-1];
      pipe_sum[i] <= pipe_sum[i-1];
    end
  end

  assign bus.tree_sum = pipe_v[PIPE_LAT-1] ? pipe_sum[PIPE_LAT-1] : 20'h5A5A5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    int          ng;
    int          bv;
    int          md;
    int          mr;
    logic [15:0] pat;
    int          lat;
    int          exp;
    int          hold;
  } vec_t;

  task automatic run_op(input vec_t v);
    int  cyc, accepts, mulcnt, errs, idx;
    bit  found, rdy_bad, zero_bad, stable_bad, vin;
    logic [7:0] mdb, mrb;
    mdb = v.md[7:0];
    mrb = v.mr[7:0];
    accepts = 0; mulcnt = 0; found = 0; rdy_bad = 0; zero_bad = 0; cyc = 0;
    bus.start      = 1'b1;
    bus.num_groups = v.ng[GRP_W-1:0];
    bus.bias       = v.bv;
    bus.in_valid   = 1'b0;
    tick();
    bus.start = 1'b0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      idx = cyc - 1;
      vin = (idx < 16) ? v.pat[idx] : 1'b1;
      bus.in_valid = vin;
      bus.in_md    = vin ? {9{mdb}} : {$urandom, $urandom, $urandom};
      bus.in_mr    = vin ? {9{mrb}} : {$urandom, $urandom, $urandom};
      #1;
      if (accepts == v.ng && bus.in_ready) rdy_bad = 1;
      if (bus.in_valid && bus.in_ready) accepts++;
      if (bus.mul_valid) mulcnt++;
      if (!bus.mul_valid && (bus.mul_md != '0 || bus.mul_mr != '0)) zero_bad = 1;
      if (bus.out_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk({v.nm, "_done_seen"}, found, 1);
    if (!found) return;
    chk({v.nm, "_latency"}, cyc, v.lat);
    chk({v.nm, "_out_data"}, $signed(bus.out_data), v.exp);
    chk({v.nm, "_mul_pulses"}, mulcnt, v.ng);
    chk({v.nm, "_ready_low_after_last"}, rdy_bad, 0);
    chk({v.nm, "_mul_zero_when_idle"}, zero_bad, 0);
    if (v.hold > 0) begin
      errs = 0; stable_bad = 0;
      for (int h = 0; h < v.hold; h++) begin
        bus.out_ready = 1'b0;
        bus.start     = (h == 3);
        tick();
        bus.start = 1'b0;
        if (bus.err_start) errs++;
        if (bus.out_valid !== 1'b1 || $signed(bus.out_data) != v.exp || bus.busy !== 1'b1)
          stable_bad = 1;
      end
      chk({v.nm, "_hold_stable"}, stable_bad, 0);
      chk({v.nm, "_err_pulse_count"}, errs, 1);
    end
    // Handshake; a start in this same cycle must be rejected.
    bus.out_ready = 1'b1;
    bus.start     = (v.hold > 0);
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk({v.nm, "_out_valid_drop"}, bus.out_valid, 0);
    chk({v.nm, "_busy_drop"}, bus.busy, 0);
    chk({v.nm, "_data_held"}, $signed(bus.out_data), v.exp);
    if (v.hold > 0) chk({v.nm, "_err_in_handshake"}, bus.err_start, 1);
    tick();
    chk({v.nm, "_idle_after"}, bus.busy, 0);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{"one_grp",   1, 0,          1,    1,    16'hFFFF, 6,  9,           0};
    vecs[1] = '{"four_neg",  4, 100,        -128, -128, 16'hFFFF, 9,  589924,      0};
    vecs[2] = '{"zero_grp",  0, -7,         1,    1,    16'hFFFF, 1,  -7,          0};
    vecs[3] = '{"bubbles",   3, 1000,       -1,   7,    16'h0029, 11, 811,         0};
    vecs[4] = '{"two_mixed", 2, -50,        3,    -5,   16'hFFFF, 7,  -320,        0};
    vecs[5] = '{"five_max",  5, 0,          127,  -128, 16'hFFFF, 10, -731520,     0};
    vecs[6] = '{"wrap",      1, 2147483647, 1,    1,    16'hFFFF, 6,  -2147483640, 0};

    bus.start = 0; bus.num_groups = '0; bus.bias = '0; bus.in_valid = 0;
    bus.in_md = '0; bus.in_mr = '0; bus.out_ready = 0;
    reset = 1'b1;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_mul_valid", bus.mul_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_err_start", bus.err_start, 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_op(vecs[i]);

    run_op('{"stall", 1, 5, 2, 2, 16'hFFFF, 6, 41, 10});

    // Reset while two sums are still in the tree.
    bus.start = 1'b1; bus.num_groups = 10'd2; bus.bias = '0;
    bus.in_valid = 1'b1; bus.in_md = {9{8'd1}}; bus.in_mr = {9{8'd1}};
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("drain_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_mul_valid", bus.mul_valid, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    tick();
    reset = 1'b0;
    tick();
    run_op('{"after_rst", 1, 0, 2, 3, 16'hFFFF, 6, 54, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
